mont_redc: RTL and testbench
============================

// Module: mont_redc
// PURPOSE
//  Word-serial Montgomery reduction: r = a * R^-1 mod n, with R = 2^N_BITS. Converts operands out of the Montgomery domain.
//  Inverse end of the domain-entry path: consumes n_inv from modInv and R / R^2 mod n from rtMod; feeds the RSA datapath result back to plain form.
// PARAMETERS
//  N_BITS  4096  modulus/operand width; must equal W*NW
//  W       64    digit width; matches modInv modulo_inv width
// PORTS
//  clk    in   1       single clock, all state on posedge
//  rst_n  in   1       asynchronous, active-low reset
//  go     in   1       start pulse; sampled only in IDLE
//  n      in   N_BITS  modulus; odd, n < R
//  n_inv  in   W       -n^-1 mod 2^W (modInv output)
//  a      in   N_BITS  operand; precondition a < n
//  r      out  N_BITS  result; valid from done until next go
//  busy   out  1       high from the cycle after go through the SUB state
//  done   out  1       one-cycle pulse when r is valid
// BEHAVIOUR
//  Reset: state=IDLE; r=0, busy=0, done=0; internal t, i, j and carry regs all cleared. Reset in any state aborts the operation.
//  IDLE: on go=1, latch n, n_inv, a; t <= {W'b0, a} (NW+1 words); i <= 0; go to MCALC. go while busy is ignored.
//  Inputs n, n_inv, a may change after the go edge without effect.
//  MCALC (1 cyc): m <= (t[0] * n_inv) mod 2^W; j <= 0; c <= 0.
//  ACC (NW cyc, j=0..NW-1): {c, s} = t[j] + m*n[j] + c, exactly 2W bits, no overflow.
//    j=0: s is discarded (always 0). j>=1: t[j-1] <= s. This fuses the >>W shift.
//  TOP (1 cyc): {cb, s} = t[NW] + c; t[NW-1] <= s; t[NW] <= cb (0/1).
//    i <= i+1; if i==NW-1 go to SUB, else go to MCALC.
//  After the loop, t < 2n.
//  SUB (NW cyc, word-serial, LSW first): r[k] <= t[k] - n[k] - borrow.
//    At the end: if t[NW]==1 or final borrow==0, keep the difference. Otherwise r <= t[NW-1:0] (one extra mux write in the same last cycle).
//    Go to DONE.
//  DONE (1 cyc): done=1, busy=0; go to IDLE. r then holds.
//  Latency: go edge to done high = NW*(NW+2) + NW + 1 cycles. This is 4289 at defaults and 11 at W=8, NW=2.
//  Boundaries:
//    a=0 gives r=0.
//    t==n exactly after the loop gives r=0 through the subtract path.
//    go in the DONE cycle is ignored; go in the next IDLE cycle starts a new run.
//  Precondition violations (a>=n, even n) give undefined r; no hang. The state machine still completes in fixed latency.
// STRUCTURE
//  Shared package/include mont_pkg:
//    state encodings IDLE/MCALC/ACC/TOP/SUB/DONE
//    localparam NW = N_BITS/W
//    index width clog2(NW+1)
//  Sub-module mont_mac: comb {c_out, s} = x + y*z + c_in, all W-bit inputs, 2W-bit result. One instance. The SUB stage reuses a plain W-bit subtractor.
//  Word selection uses indexed part-selects t[j*W +: W]. Store t as (NW+1)*W bits.
// TESTING
//  Small config W=8, NW=2, N_BITS=16. Use n=77, n_inv=123, R mod n=9, R^-1 mod n=60.
//  1) a=9 -> r=1 (REDC of R mod n); done exactly 11 cycles after the go edge.
//  2) a=1 -> r=60; a=4 (R^2 mod n) -> r=9; a=76 -> r=17. Covers the final-subtract taken and not taken.
//  3) a=0 -> r=0; busy high throughout, done a single-cycle pulse, r stable until the next go.
//  4) Pulse go again at busy cycles 3 and 7, and change a mid-run -> ignored; the result matches the originally latched a.
//  5) Assert rst_n=0 mid-ACC -> outputs zero immediately; a new go after release gives a correct result.
//  6) Default params: feed rtMod mode0 output (R mod n) and modInv output for a 4096-bit n -> r=1 at 4289 cycles. Random a<n checked against a behavioural model.

Source files
------------

// File: rtl/mont_redc_pkg.sv
// Shared types and sizing helpers for the word-serial Montgomery reduction block.
package mont_redc_pkg;

  localparam int unsigned N_BITS_DEF = 4096;
  localparam int unsigned W_DEF      = 64;
  localparam int unsigned NW_DEF     = N_BITS_DEF / W_DEF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MCALC,
    ST_ACC,
    ST_TOP,
    ST_SUB,
    ST_DONE
  } state_e;

  // Word index counters must be able to hold NW itself (outer loop end value).
  function automatic int unsigned idx_width(input int unsigned nw);
    return $clog2(nw + 1);
  endfunction

endpackage

// File: rtl/mont_redc_if.sv
// Start/operand/result bundle between a requester and mont_redc.
interface mont_redc_if #(
  parameter int unsigned N_BITS = mont_redc_pkg::N_BITS_DEF,
  parameter int unsigned W      = mont_redc_pkg::W_DEF
);
  logic              go;
  logic [N_BITS-1:0] n;
  logic [W-1:0]      n_inv;
  logic [N_BITS-1:0] a;
  logic [N_BITS-1:0] r;
  logic              busy;
  logic              done;

  modport master (output go, n, n_inv, a, input r, busy, done);
  modport slave  (input go, n, n_inv, a, output r, busy, done);
endinterface

// File: rtl/mont_redc_mac.sv
// Single-digit multiply-accumulate: {c_out, s} = x + y*z + c_in, never overflows 2W bits.
module mont_mac #(
  parameter int unsigned W = 64
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic [W-1:0] z,
  input  logic [W-1:0] c_in,
  output logic [W-1:0] c_out,
  output logic [W-1:0] s
);
  localparam int unsigned W2 = 2 * W;

  logic [W2-1:0] full;

  assign full       = W2'(x) + W2'(y) * W2'(z) + W2'(c_in);
  assign {c_out, s} = full;
endmodule

// File: rtl/mont_redc.sv
// Word-serial Montgomery reduction r = a * 2^-N_BITS mod n with a final conditional subtract.
module mont_redc
  import mont_redc_pkg::*;
#(
  parameter int unsigned N_BITS = N_BITS_DEF,
  parameter int unsigned W      = W_DEF
) (
  input logic       clk,
  input logic       rst_n,
  mont_redc_if.slave bus
);
  localparam int unsigned NW    = N_BITS / W;
  localparam int unsigned IW    = idx_width(NW);
  localparam int unsigned TW    = (NW + 1) * W;
  localparam int unsigned TOPLO = NW * W;
  localparam logic [IW-1:0] LAST = IW'(NW - 1);

  state_e            state_q, state_d;
  logic [TW-1:0]     t_q, t_d;
  logic [N_BITS-1:0] n_q, n_d;
  logic [W-1:0]      ninv_q, ninv_d;
  logic [W-1:0]      m_q, m_d;
  logic [W-1:0]      c_q, c_d;
  logic              borrow_q, borrow_d;
  logic [IW-1:0]     i_q, i_d;
  logic [IW-1:0]     j_q, j_d;
  logic [N_BITS-1:0] r_q, r_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [W-1:0] t_word, n_word;
  logic [W-1:0] mac_x, mac_y, mac_z, mac_c, mac_co, mac_s;
  logic [W:0]   top_sum;
  logic [W:0]   sub_full;
  logic         keep_diff;

  assign t_word    = t_q[int'(j_q) * W +: W];
  assign n_word    = n_q[int'(j_q) * W +: W];
  assign top_sum   = {1'b0, t_q[TW-1 -: W]} + {1'b0, c_q};
  assign sub_full  = {1'b0, t_word} - {1'b0, n_word} - (W+1)'(borrow_q);
  assign keep_diff = t_q[TOPLO] | ~sub_full[W];

  // MCALC borrows the multiplier for m = t[0]*n_inv; otherwise it does the digit MAC.
  always_comb begin
    mac_x = t_word;
    mac_y = m_q;
    mac_z = n_word;
    mac_c = c_q;
    if (state_q == ST_MCALC) begin
      mac_x = '0;
      mac_y = t_q[W-1:0];
      mac_z = ninv_q;
      mac_c = '0;
    end
  end

  mont_mac #(.W(W)) u_mac (
    .x     (mac_x),
    .y     (mac_y),
    .z     (mac_z),
    .c_in  (mac_c),
    .c_out (mac_co),
    .s     (mac_s)
  );

  always_comb begin
    state_d  = state_q;
    t_d      = t_q;
    n_d      = n_q;
    ninv_d   = ninv_q;
    m_d      = m_q;
    c_d      = c_q;
    borrow_d = borrow_q;
    i_d      = i_q;
    j_d      = j_q;
    r_d      = r_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.go) begin
          n_d     = bus.n;
          ninv_d  = bus.n_inv;
          t_d     = {W'(0), bus.a};
          i_d     = '0;
          j_d     = '0;
          c_d     = '0;
          state_d = ST_MCALC;
        end
      end
      ST_MCALC: begin
        m_d     = mac_s;
        j_d     = '0;
        c_d     = '0;
        state_d = ST_ACC;
      end
      ST_ACC: begin
        // Word j lands in slot j-1: the divide by 2^W is folded into the write-back.
        c_d = mac_co;
        if (j_q != '0) t_d[(int'(j_q) - 1) * W +: W] = mac_s;
        if (j_q == LAST) state_d = ST_TOP;
        else             j_d     = j_q + IW'(1);
      end
      ST_TOP: begin
        t_d[TOPLO-1 -: W] = top_sum[W-1:0];
        t_d[TW-1 -: W]    = W'(top_sum[W]);
        i_d               = i_q + IW'(1);
        j_d               = '0;
        borrow_d          = 1'b0;
        state_d           = (i_q == LAST) ? ST_SUB : ST_MCALC;
      end
      ST_SUB: begin
        r_d[int'(j_q) * W +: W] = sub_full[W-1:0];
        borrow_d                = sub_full[W];
        j_d                     = j_q + IW'(1);
        if (j_q == LAST) begin
          if (!keep_diff) r_d = t_q[N_BITS-1:0];
          j_d     = '0;
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE) && (state_d != ST_DONE);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      t_q      <= '0;
      n_q      <= '0;
      ninv_q   <= '0;
      m_q      <= '0;
      c_q      <= '0;
      borrow_q <= 1'b0;
      i_q      <= '0;
      j_q      <= '0;
      r_q      <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      t_q      <= t_d;
      n_q      <= n_d;
      ninv_q   <= ninv_d;
      m_q      <= m_d;
      c_q      <= c_d;
      borrow_q <= borrow_d;
      i_q      <= i_d;
      j_q      <= j_d;
      r_q      <= r_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.r    = r_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule

// File: tb/tb_mont_redc.sv
// Bench for mont_redc: small W=8/NW=2 instance with vector table and corner sequences,
// plus a full-size 4096-bit instance checked against a bit-serial halving model.
module tb_mont_redc;
  localparam int unsigned SN = 16;
  localparam int unsigned SW = 8;
  localparam int unsigned BN = 4096;
  localparam int unsigned BW = 64;
  localparam int SMALL_LAT = 11;
  localparam int BIG_LAT   = 4289;

  logic clk = 1'b0;
  logic rst_n;
  int   total  = 0;
  int   passed = 0;

  typedef struct {
    logic [15:0] a;
    logic [15:0] exp_r;
    bit          disturb;
  } vec_t;

  vec_t vecs[6];

  mont_redc_if #(.N_BITS(SN), .W(SW)) s_if ();
  mont_redc_if #(.N_BITS(BN), .W(BW)) b_if ();

  mont_redc #(.N_BITS(SN), .W(SW)) u_small (.clk(clk), .rst_n(rst_n), .bus(s_if.slave));
  mont_redc #(.N_BITS(BN), .W(BW)) u_big   (.clk(clk), .rst_n(rst_n), .bus(b_if.slave));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // a * 2^-nbits mod n by halving modulo odd n, one bit at a time.
  function automatic logic [4095:0] redc_ref(input logic [4095:0] a, input logic [4095:0] n,
                                             input int nbits);
    logic [4096:0] x;
    x = {1'b0, a};
    for (int k = 0; k < nbits; k++) begin
      if (x[0]) x = x + {1'b0, n};
      x = x >> 1;
    end
    return x[4095:0];
  endfunction

  // -n0^-1 mod 2^64 by Newton iteration.
  function automatic logic [63:0] neg_inv64(input logic [63:0] n0);
    logic [63:0] x;
    x = n0;
    for (int k = 0; k < 6; k++) x = x * (64'd2 - n0 * x);
    return -x;
  endfunction

  // Caller is at a negedge; returns at the negedge where done is seen (or bound hit).
  task automatic run_small(input logic [15:0] av, input bit disturb,
                           output logic [15:0] rv, output int lat, output bit bok);
    lat = 0;
    bok = 1'b1;
    s_if.a     = av;
    s_if.n     = 16'd77;
    s_if.n_inv = 8'd123;
    s_if.go    = 1'b1;
    @(posedge clk);
    do begin
      @(negedge clk);
      lat++;
      if (s_if.done === 1'b1) begin
        if (s_if.busy !== 1'b0) bok = 1'b0;
      end else if (s_if.busy !== 1'b1) bok = 1'b0;
      s_if.go = disturb && (lat == 3 || lat == 7);
      if (disturb) begin
        s_if.a     = 16'($urandom);
        s_if.n     = 16'($urandom);
        s_if.n_inv = 8'($urandom);
      end
    end while (s_if.done !== 1'b1 && lat < 50);
    rv = s_if.r;
  endtask

  task automatic run_big(input logic [4095:0] av, input logic [4095:0] nv, input logic [63:0] ninv,
                         output logic [4095:0] rv, output int lat, output bit bok);
    lat = 0;
    bok = 1'b1;
    b_if.a     = av;
    b_if.n     = nv;
    b_if.n_inv = ninv;
    b_if.go    = 1'b1;
    @(posedge clk);
    do begin
      @(negedge clk);
      lat++;
      if (b_if.done === 1'b1) begin
        if (b_if.busy !== 1'b0) bok = 1'b0;
      end else if (b_if.busy !== 1'b1) bok = 1'b0;
      b_if.go = 1'b0;
      if (lat == 2) b_if.a = ~av;
    end while (b_if.done !== 1'b1 && lat < 5000);
    rv = b_if.r;
  endtask

  initial begin
    logic [15:0]   rs;
    logic [15:0]   exp_s;
    logic [4095:0] wide;
    logic [4095:0] bn, ba, br, bexp;
    logic [63:0]   bninv;
    int            lat;
    bit            bok;

    vecs[0] = '{16'd9,  16'd1,  1'b0};
    vecs[1] = '{16'd1,  16'd60, 1'b0};
    vecs[2] = '{16'd4,  16'd9,  1'b0};
    vecs[3] = '{16'd76, 16'd17, 1'b0};
    vecs[4] = '{16'd0,  16'd0,  1'b0};
    vecs[5] = '{16'd76, 16'd17, 1'b1};

    rst_n = 1'b0;
    s_if.go = 1'b0; s_if.n = '0; s_if.n_inv = '0; s_if.a = '0;
    b_if.go = 1'b0; b_if.n = '0; b_if.n_inv = '0; b_if.a = '0;
    repeat (3) @(negedge clk);
    chk("rst_small_r",    64'(s_if.r),    64'd0);
    chk("rst_small_busy", 64'(s_if.busy), 64'd0);
    chk("rst_small_done", 64'(s_if.done), 64'd0);
    chk("rst_big_r_lo",   b_if.r[63:0],   64'd0);
    chk("rst_big_busy",   64'(b_if.busy), 64'd0);
    chk("rst_big_done",   64'(b_if.done), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Table: spec vectors, last entry re-pulses go and scrambles inputs mid-run.
    foreach (vecs[v]) begin
      run_small(vecs[v].a, vecs[v].disturb, rs, lat, bok);
      chk($sformatf("vec%0d_r", v),    64'(rs),  64'(vecs[v].exp_r));
      chk($sformatf("vec%0d_lat", v),  64'(lat), 64'(SMALL_LAT));
      chk($sformatf("vec%0d_busy", v), 64'(bok), 64'd1);
      s_if.go = 1'b0;
      @(negedge clk);
      chk($sformatf("vec%0d_done_pulse", v), 64'(s_if.done), 64'd0);
      chk($sformatf("vec%0d_busy_idle", v),  64'(s_if.busy), 64'd0);
      repeat (3) @(negedge clk);
      chk($sformatf("vec%0d_r_hold", v), 64'(s_if.r), 64'(vecs[v].exp_r));
    end

    // go during DONE is ignored; held into IDLE it starts a fresh run.
    run_small(16'd1, 1'b0, rs, lat, bok);
    chk("pre_done_r", 64'(rs), 64'd60);
    s_if.go = 1'b1;
    s_if.a  = 16'd9;
    @(negedge clk);
    chk("go_in_done_busy", 64'(s_if.busy), 64'd0);
    chk("go_in_done_r",    64'(s_if.r),    64'd60);
    run_small(16'd9, 1'b0, rs, lat, bok);
    chk("go_after_done_r",   64'(rs),  64'd1);
    chk("go_after_done_lat", 64'(lat), 64'(SMALL_LAT));
    s_if.go = 1'b0;
    @(negedge clk);

    // Reset asserted in ACC clears outputs immediately; next run is clean.
    s_if.a = 16'd4; s_if.n = 16'd77; s_if.n_inv = 8'd123; s_if.go = 1'b1;
    @(posedge clk);
    @(negedge clk);
    s_if.go = 1'b0;
    @(negedge clk);
    chk("mid_acc_busy", 64'(s_if.busy), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_r",    64'(s_if.r),    64'd0);
    chk("rst_mid_busy", 64'(s_if.busy), 64'd0);
    chk("rst_mid_done", 64'(s_if.done), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_busy", 64'(s_if.busy), 64'd0);
    run_small(16'd4, 1'b0, rs, lat, bok);
    chk("post_rst_r",   64'(rs),  64'd9);
    chk("post_rst_lat", 64'(lat), 64'(SMALL_LAT));
    s_if.go = 1'b0;
    @(negedge clk);

    // Random small operands against the model.
    for (int k = 0; k < 10; k++) begin
      logic [15:0] ra;
      ra   = 16'($urandom_range(76, 0));
      wide = redc_ref(4096'(ra), 4096'(77), 16);
      exp_s = wide[15:0];
      run_small(ra, 1'b0, rs, lat, bok);
      chk($sformatf("rand_small%0d_a%0d_r", k, ra), 64'(rs), 64'(exp_s));
      s_if.go = 1'b0;
      @(negedge clk);
    end

    // Full size: odd n above R/2 so R mod n = R - n.
    for (int k = 0; k < 64; k++) bn[k*64 +: 64] = {$urandom, $urandom};
    bn[4095] = 1'b1;
    bn[0]    = 1'b1;
    bninv = neg_inv64(bn[63:0]);
    ba = -bn;
    run_big(ba, bn, bninv, br, lat, bok);
    chk("big_rmodn_r_lo",   br[63:0],         64'd1);
    chk("big_rmodn_r_full", 64'(br == 4096'(1)), 64'd1);
    chk("big_rmodn_lat",    64'(lat),         64'(BIG_LAT));
    chk("big_rmodn_busy",   64'(bok),         64'd1);
    @(negedge clk);

    for (int k = 0; k < 2; k++) begin
      for (int w = 0; w < 64; w++) ba[w*64 +: 64] = {$urandom, $urandom};
      ba[4095] = 1'b0;
      bexp = redc_ref(ba, bn, 4096);
      run_big(ba, bn, bninv, br, lat, bok);
      chk($sformatf("big_rand%0d_r_lo", k),   br[63:0],            bexp[63:0]);
      chk($sformatf("big_rand%0d_r_full", k), 64'(br == bexp),     64'd1);
      chk($sformatf("big_rand%0d_lat", k),    64'(lat),            64'(BIG_LAT));
      @(negedge clk);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
